lsu_ahbl: RTL and testbench
===========================

LSU_AHBL -- requirements
Module: lsu_ahbl

Interface
REQ-001 Parameter ADDR_W, default 32, width of req_addr and dbus_haddr (legal 12..32).
REQ-002 Parameter HPROT_VAL, default 4'b0011, constant driven on dbus_hport.
REQ-003 Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  pipeline memory request.
- req_ready  out  1  request accepted this cycle if req_valid.
- req_wr  in  1  1 store, 0 load.
- req_size  in  2  0 byte, 1 half, 2 word; 3 illegal.
- req_unsigned  in  1  zero-extend load (LBU/LHU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_err  out  1  bus error (hresp) on completion.
- rsp_misaligned  out  1  misaligned or illegal-size request on completion.
- busy  out  1  transfer in flight; pipeline stall source.
- dbus_haddr  out  ADDR_W,  dbus_hwrite  out  1,  dbus_hsize  out  3,  dbus_hburst  out  3,  dbus_hport  out  4,  dbus_htrans  out  2,  dbus_hmastlock  out  1,  dbus_hwdata  out  32  AHB-Lite master outputs.
- dbus_hready  in  1,  dbus_hresp  in  1,  dbus_hrdata  in  32  AHB-Lite slave returns.

Function
REQ-004 FSM states IDLE, ADDR, DATA; single outstanding transfer, no pipelining.
REQ-005 req_ready = (state==IDLE); busy = (state!=IDLE).
REQ-006 IDLE, req_valid & aligned & req_size!=3: latch addr/size/wr/unsigned/wdata, go ADDR.
REQ-007 Misaligned = (size 1 & addr[0]) | (size 2 & addr[1:0]!=0); such request, or size 3: stay IDLE, no bus activity, next cycle rsp_valid=1, rsp_misaligned=1, rsp_err=0, rsp_rdata=0.
REQ-008 ADDR: dbus_htrans=2'b10 (NONSEQ), haddr/hwrite/hsize={1'b0,size} from latched values; hready=1 -> DATA, else hold all address-phase outputs stable.
REQ-009 DATA: dbus_htrans=2'b00; dbus_hwdata driven whole phase: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata; stays stable while hready=0.
REQ-010 DATA & hready=1: next cycle rsp_valid=1, rsp_err=dbus_hresp, state IDLE.
REQ-011 Load data: byte lane hrdata[8*addr[1:0]+:8], half lane hrdata[16*addr[1]+:16], sign- or zero-extended per req_unsigned; word unchanged; registered into rsp_rdata at completion.
REQ-012 rsp_rdata=0 for stores and when hresp=1.
REQ-013 hresp=1 with hready=0 (first error cycle): stay DATA, no action; completion on second cycle per REQ-010.
REQ-014 Outside ADDR: dbus_htrans=IDLE; haddr/hwrite/hsize retain last values.
REQ-015 dbus_hburst=3'b000, dbus_hmastlock=0, dbus_hport=HPROT_VAL at all times.
REQ-016 Latency, zero wait states: accept cycle N, ADDR N+1, DATA N+2, rsp_valid N+3; each hready-low cycle adds one.
REQ-017 rsp_valid in IDLE may coincide with acceptance of the next request (back-to-back, 3-cycle issue interval).
REQ-018 req_valid while busy: ignored, no latching; requester holds it.
REQ-019 Address arithmetic truncated to ADDR_W; no wrap detection.

Reset
REQ-020 rst=1 asynchronously forces IDLE; rsp_valid=0, rsp_err=0, rsp_misaligned=0, rsp_rdata=0, dbus_htrans=2'b00, dbus_haddr=0, dbus_hwrite=0, dbus_hsize=0, dbus_hwdata=0.
REQ-021 Reset mid-transfer: transfer discarded, no rsp_valid; first request after deassert behaves per REQ-006.

Verification
REQ-022 LW addr 0x100, zero wait, hrdata=0xDEADBEEF -> NONSEQ at N+1, rsp_valid at N+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-023 LB addr 0x103, hrdata=0x80FF_0000 -> 0xFFFFFF80; LBU -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
REQ-024 SB addr 0x201, wdata=0x12345678, hready low 2 DATA cycles -> hsize=0, hwdata=0x78787878 held stable, rsp_valid at N+5.
REQ-025 LW addr 0x102 -> no NONSEQ, rsp_valid next cycle with rsp_misaligned=1; req_size=3 same.
REQ-026 Error: DATA cycle hresp=1/hready=0 then hresp=1/hready=1 -> rsp_err=1, rsp_rdata=0, back to IDLE.
REQ-027 rst asserted in DATA with hready=0 -> htrans=IDLE, busy=0 same cycle, no rsp_valid; next LW completes normally.

Source files
------------

// File: rtl/lsu_ahbl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ahbl
//  Purpose  : Load/store unit front end driving a single-outstanding
//             AHB-Lite master port. Handles byte/half/word access,
//             store lane replication, load extraction with sign/zero
//             extension, misalignment rejection and bus-error reporting.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_ahbl #(
    parameter int          ADDR_W    = 32,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic              clk,
    input  logic              rst,
    // pipeline request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    // pipeline response
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_misaligned,
    output logic              busy,
    // AHB-Lite master
    output logic [ADDR_W-1:0] dbus_haddr,
    output logic              dbus_hwrite,
    output logic [2:0]        dbus_hsize,
    output logic [2:0]        dbus_hburst,
    output logic [3:0]        dbus_hport,
    output logic [1:0]        dbus_htrans,
    output logic              dbus_hmastlock,
    output logic [31:0]       dbus_hwdata,
    input  logic              dbus_hready,
    input  logic              dbus_hresp,
    input  logic [31:0]       dbus_hrdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_wr;
    logic              r_unsigned;
    logic [31:0]       r_hwdata;

    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_rsp_mis;
    logic [31:0]       r_rsp_rdata;

    logic              w_misaligned;
    logic              w_accept;
    logic              w_reject;
    logic              w_done;
    logic [31:0]       w_wdata_rep;
    logic [7:0]        w_lane_b;
    logic [15:0]       w_lane_h;
    logic [31:0]       w_load_ext;

    // Request qualification: size 3 is folded into the misaligned path
    always_comb begin
        w_misaligned = ((req_size == 2'd1) && req_addr[0])
                     || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
                     || (req_size == 2'd3);
        w_accept     = (r_state == S_IDLE) && req_valid && !w_misaligned;
        w_reject     = (r_state == S_IDLE) && req_valid &&  w_misaligned;
        w_done       = (r_state == S_DATA) && dbus_hready;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: one transfer at a time, ADDR and DATA wait on hready
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_state_nxt = S_ADDR;
            S_ADDR:  if (dbus_hready) w_state_nxt = S_DATA;
            S_DATA:  if (dbus_hready) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // Store data replicated across all lanes the access can hit
    always_comb begin
        w_wdata_rep = req_wdata;
        case (req_size)
            2'd0:    w_wdata_rep = {4{req_wdata[7:0]}};
            2'd1:    w_wdata_rep = {2{req_wdata[15:0]}};
            default: w_wdata_rep = req_wdata;
        endcase
    end

    // Latch the accepted request; values persist after the transfer ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_size     <= 2'd0;
            r_wr       <= 1'b0;
            r_unsigned <= 1'b0;
            r_hwdata   <= 32'd0;
        end else if (w_accept) begin
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_wr       <= req_wr;
            r_unsigned <= req_unsigned;
            r_hwdata   <= w_wdata_rep;
        end
    end

    // Load lane extraction and sign/zero extension from the latched address
    always_comb begin
        w_lane_b = dbus_hrdata[7:0];
        case (r_addr[1:0])
            2'd0: w_lane_b = dbus_hrdata[7:0];
            2'd1: w_lane_b = dbus_hrdata[15:8];
            2'd2: w_lane_b = dbus_hrdata[23:16];
            2'd3: w_lane_b = dbus_hrdata[31:24];
            default: w_lane_b = dbus_hrdata[7:0];
        endcase
        w_lane_h = r_addr[1] ? dbus_hrdata[31:16] : dbus_hrdata[15:0];
        case (r_size)
            2'd0:    w_load_ext = r_unsigned ? {24'd0, w_lane_b}
                                             : {{24{w_lane_b[7]}}, w_lane_b};
            2'd1:    w_load_ext = r_unsigned ? {16'd0, w_lane_h}
                                             : {{16{w_lane_h[15]}}, w_lane_h};
            default: w_load_ext = dbus_hrdata;
        endcase
    end

    // Response pulse: bus completion or immediate misalignment rejection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_mis   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_mis   <= 1'b0;
            r_rsp_rdata <= 32'd0;
            if (w_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= dbus_hresp;
                r_rsp_rdata <= (r_wr || dbus_hresp) ? 32'd0 : w_load_ext;
            end else if (w_reject) begin
                r_rsp_valid <= 1'b1;
                r_rsp_mis   <= 1'b1;
            end
        end
    end

    // Output mapping; htrans/busy follow the state so reset clears them at once
    always_comb begin
        req_ready      = (r_state == S_IDLE);
        busy           = (r_state != S_IDLE);
        rsp_valid      = r_rsp_valid;
        rsp_err        = r_rsp_err;
        rsp_misaligned = r_rsp_mis;
        rsp_rdata      = r_rsp_rdata;
        dbus_htrans    = (r_state == S_ADDR) ? c_htrans_nonseq : c_htrans_idle;
        dbus_haddr     = r_addr;
        dbus_hwrite    = r_wr;
        dbus_hsize     = {1'b0, r_size};
        dbus_hwdata    = r_hwdata;
        dbus_hburst    = 3'b000;
        dbus_hmastlock = 1'b0;
        dbus_hport     = HPROT_VAL;
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ahbl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ahbl
//  Purpose  : Directed self-checking bench for lsu_ahbl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_ahbl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, rsp_misaligned, busy;
    logic [31:0] rsp_rdata;
    logic [31:0] dbus_haddr, dbus_hwdata, dbus_hrdata;
    logic        dbus_hwrite, dbus_hmastlock, dbus_hready, dbus_hresp;
    logic [2:0]  dbus_hsize, dbus_hburst;
    logic [3:0]  dbus_hport;
    logic [1:0]  dbus_htrans;

    int n_cmp = 0;
    int n_err = 0;

    lsu_ahbl #(.ADDR_W(32), .HPROT_VAL(4'b0011)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_misaligned(rsp_misaligned), .busy(busy),
        .dbus_haddr(dbus_haddr), .dbus_hwrite(dbus_hwrite), .dbus_hsize(dbus_hsize),
        .dbus_hburst(dbus_hburst), .dbus_hport(dbus_hport), .dbus_htrans(dbus_htrans),
        .dbus_hmastlock(dbus_hmastlock), .dbus_hwdata(dbus_hwdata),
        .dbus_hready(dbus_hready), .dbus_hresp(dbus_hresp), .dbus_hrdata(dbus_hrdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full bus transfer with `waits` hready-low DATA cycles; starts in an IDLE cycle
    task automatic xfer(input string tag, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] hrdata, input int waits,
                        input logic [31:0] exp_hwdata, input logic [31:0] exp_rdata);
        req_valid = 1'b1; req_wr = wr; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        chk({tag, "_a_htrans"}, {30'd0, dbus_htrans}, 32'd2);
        chk({tag, "_a_haddr"},  dbus_haddr, addr);
        chk({tag, "_a_hwrite"}, {31'd0, dbus_hwrite}, {31'd0, wr});
        chk({tag, "_a_hsize"},  {29'd0, dbus_hsize}, {30'd0, size});
        chk({tag, "_a_busy"},   {31'd0, busy}, 32'd1);
        step();
        dbus_hrdata = hrdata;
        for (int i = 0; i < waits; i++) begin
            dbus_hready = 1'b0;
            chk({tag, "_w_htrans"}, {30'd0, dbus_htrans}, 32'd0);
            chk({tag, "_w_hwdata"}, dbus_hwdata, exp_hwdata);
            step();
        end
        chk({tag, "_d_htrans"}, {30'd0, dbus_htrans}, 32'd0);
        chk({tag, "_d_hwdata"}, dbus_hwdata, exp_hwdata);
        chk({tag, "_d_rspv"},   {31'd0, rsp_valid}, 32'd0);
        dbus_hready = 1'b1;
        step();
        chk({tag, "_rspv"},  {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_err"},   {31'd0, rsp_err}, 32'd0);
        chk({tag, "_mis"},   {31'd0, rsp_misaligned}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        dbus_hready = 1'b1; dbus_hresp = 1'b0; dbus_hrdata = 32'd0;
        step(); step();
        // Reset state
        chk("rst_rspv",   {31'd0, rsp_valid}, 32'd0);
        chk("rst_htrans", {30'd0, dbus_htrans}, 32'd0);
        chk("rst_haddr",  dbus_haddr, 32'd0);
        chk("rst_hwdata", dbus_hwdata, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_hport",  {28'd0, dbus_hport}, 32'h3);
        chk("rst_hburst", {29'd0, dbus_hburst}, 32'd0);
        rst = 1'b0;
        step();

        // LW zero wait, then back-to-back byte/half loads
        xfer("lw",  1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h0, 32'hDEADBEEF);
        xfer("lb",  1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF0000, 0, 32'h0, 32'hFFFFFF80);
        xfer("lbu", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 0, 32'h0, 32'h00000080);
        xfer("lh",  1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80FF0000, 0, 32'h0, 32'hFFFF80FF);
        xfer("lhu", 1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'h12348001, 0, 32'h0, 32'h00008001);
        // Stores: byte with two wait states, half zero wait
        xfer("sb",  1'b1, 2'd0, 1'b0, 32'h201, 32'h12345678, 32'hFFFFFFFF, 2, 32'h78787878, 32'h0);
        xfer("sh",  1'b1, 2'd1, 1'b0, 32'h102, 32'hAAAABEEF, 32'hFFFFFFFF, 0, 32'hBEEFBEEF, 32'h0);
        step();

        // Misaligned word and illegal size: rejected without bus activity
        req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_addr = 32'h102;
        step();
        req_valid = 1'b0;
        chk("mis_htrans", {30'd0, dbus_htrans}, 32'd0);
        chk("mis_busy",   {31'd0, busy}, 32'd0);
        chk("mis_rspv",   {31'd0, rsp_valid}, 32'd1);
        chk("mis_flag",   {31'd0, rsp_misaligned}, 32'd1);
        chk("mis_err",    {31'd0, rsp_err}, 32'd0);
        chk("mis_rdata",  rsp_rdata, 32'd0);
        req_valid = 1'b1; req_size = 2'd3; req_addr = 32'h100;
        step();
        req_valid = 1'b0;
        chk("sz3_htrans", {30'd0, dbus_htrans}, 32'd0);
        chk("sz3_rspv",   {31'd0, rsp_valid}, 32'd1);
        chk("sz3_flag",   {31'd0, rsp_misaligned}, 32'd1);
        step();
        chk("sz3_pulse",  {31'd0, rsp_valid}, 32'd0);

        // Bus error: one hready-low error cycle then completion; new request held while busy is ignored
        req_valid = 1'b1; req_size = 2'd2; req_wr = 1'b0; req_addr = 32'h300;
        step();
        req_addr = 32'h900;
        chk("err_a_htrans", {30'd0, dbus_htrans}, 32'd2);
        step();
        chk("err_ignore_haddr", dbus_haddr, 32'h300);
        req_valid = 1'b0;
        dbus_hresp = 1'b1; dbus_hready = 1'b0; dbus_hrdata = 32'h55555555;
        step();
        chk("err_hold_busy", {31'd0, busy}, 32'd1);
        chk("err_hold_rspv", {31'd0, rsp_valid}, 32'd0);
        dbus_hready = 1'b1;
        step();
        dbus_hresp = 1'b0;
        chk("err_rspv",  {31'd0, rsp_valid}, 32'd1);
        chk("err_flag",  {31'd0, rsp_err}, 32'd1);
        chk("err_rdata", rsp_rdata, 32'd0);
        chk("err_busy",  {31'd0, busy}, 32'd0);
        step();

        // Reset in a stalled DATA phase
        req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h400;
        step();
        req_valid = 1'b0;
        step();
        dbus_hready = 1'b0;
        step();
        chk("rstm_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstm_htrans", {30'd0, dbus_htrans}, 32'd0);
        chk("rstm_busy",   {31'd0, busy}, 32'd0);
        chk("rstm_haddr",  dbus_haddr, 32'd0);
        step();
        chk("rstm_rspv",   {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0; dbus_hready = 1'b1;
        step();
        chk("rstm_rspv2",  {31'd0, rsp_valid}, 32'd0);
        xfer("lw2", 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'h0BADF00D, 0, 32'h0, 32'h0BADF00D);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
